// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline.
// Holds the default datapath widths, the named bit positions inside the
// decoded control bundle, and the hard-wired zero register specifier.
package mips_pkg;

  // Default datapath widths
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned CTRL_W = 9;
  localparam int unsigned CNT_W  = 16;

  // Control bundle bit positions
  localparam int unsigned CTRL_REGWRITE  = 8;
  localparam int unsigned CTRL_MEMTOREG  = 7;
  localparam int unsigned CTRL_MEMREAD   = 6;
  localparam int unsigned CTRL_MEMWRITE  = 5;
  localparam int unsigned CTRL_BRANCH    = 4;
  localparam int unsigned CTRL_ALUSRC    = 3;
  localparam int unsigned CTRL_REGDST    = 2;
  localparam int unsigned CTRL_ALUOP_LSB = 0;
  localparam int unsigned CTRL_ALUOP_W   = 2;

  // $0 is hard-wired to zero, so it never carries a real dependency
  localparam logic [REG_AW-1:0] REG_ZERO = REG_AW'(0);

endpackage : mips_pkg

// File: rtl/id_ex_register_if.sv
// ID/EX stage boundary bundle.
// master : the decode side (drives id_* operands/specifiers/control and Flush,
//          observes the ex_* copies, Stall and the event counters)
// slave  : the ID/EX register itself
interface id_ex_register_if #(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW,
  parameter int unsigned CTRL_W = mips_pkg::CTRL_W,
  parameter int unsigned CNT_W  = mips_pkg::CNT_W
) ();

  // Decode-stage side
  logic [DATA_W-1:0] id_PCplus4;
  logic [DATA_W-1:0] id_Readdata1;
  logic [DATA_W-1:0] id_Readdata2;
  logic [DATA_W-1:0] id_ReaddataExtra;
  logic [DATA_W-1:0] id_Imm;
  logic [REG_AW-1:0] id_Rs;
  logic [REG_AW-1:0] id_Rt;
  logic [REG_AW-1:0] id_Rd;
  logic [CTRL_W-1:0] id_Ctrl;
  logic              Flush;

  // Execute-stage side
  logic [DATA_W-1:0] ex_PCplus4;
  logic [DATA_W-1:0] ex_Data1;
  logic [DATA_W-1:0] ex_Data2;
  logic [DATA_W-1:0] ex_DataExtra;
  logic [DATA_W-1:0] ex_Imm;
  logic [REG_AW-1:0] ex_Rs;
  logic [REG_AW-1:0] ex_Rt;
  logic [REG_AW-1:0] ex_Rd;
  logic [CTRL_W-1:0] ex_Ctrl;

  // Hazard and debug
  logic              Stall;
  logic [CNT_W-1:0]  StallCount;
  logic [CNT_W-1:0]  FlushCount;

  modport master (
    output id_PCplus4, id_Readdata1, id_Readdata2, id_ReaddataExtra, id_Imm,
    output id_Rs, id_Rt, id_Rd, id_Ctrl, Flush,
    input  ex_PCplus4, ex_Data1, ex_Data2, ex_DataExtra, ex_Imm,
    input  ex_Rs, ex_Rt, ex_Rd, ex_Ctrl,
    input  Stall, StallCount, FlushCount
  );

  modport slave (
    input  id_PCplus4, id_Readdata1, id_Readdata2, id_ReaddataExtra, id_Imm,
    input  id_Rs, id_Rt, id_Rd, id_Ctrl, Flush,
    output ex_PCplus4, ex_Data1, ex_Data2, ex_DataExtra, ex_Imm,
    output ex_Rs, ex_Rt, ex_Rd, ex_Ctrl,
    output Stall, StallCount, FlushCount
  );

endinterface : id_ex_register_if

// File: rtl/id_ex_register_hazard_detect.sv
// Load-use hazard detector.
// A load sitting in EX whose destination (rt) is a source of the instruction
// in ID cannot be satisfied by forwarding, so one bubble is required.
// Ports:
//   ex_memread : MemRead bit of the instruction currently in EX
//   ex_rt      : destination specifier of the EX load
//   id_rs/id_rt: source specifiers of the ID instruction
//   flush      : ID instruction is wrong-path; suppresses the stall request
//   hazard_c   : raw load-use condition (combinational)
//   stall_c    : hold PC and IF/ID this cycle (combinational)
module hazard_detect
  import mips_pkg::*;
#(
  parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              flush,
  output logic              hazard_c,
  output logic              stall_c
);

  logic dest_nonzero;
  logic src_match;

  // A load into $0 produces nothing to wait for
  assign dest_nonzero = (ex_rt != REG_AW'(REG_ZERO));
  assign src_match    = (ex_rt == id_rs) || (ex_rt == id_rt);

  assign hazard_c = ex_memread && dest_nonzero && src_match;

  // A wrong-path instruction is about to be squashed, holding it is pointless
  assign stall_c  = hazard_c && !flush;

endmodule : hazard_detect

// File: rtl/id_ex_register.sv
// ID/EX pipeline register of the 5-stage MIPS core.
// Captures operands, immediate, specifiers, PC+4 and control from decode on
// every rising clock edge, replacing them with an all-zero bubble when the ID
// instruction is flushed (branch taken) or must wait on a load in EX.
// Ports:
//   clock   : pipeline clock, rising edge active
//   reset_n : asynchronous active-low reset, clears every ex_* field and counter
//   bus     : ID/EX bundle (slave side) -- id_* in, Flush in, ex_* out,
//             Stall out (combinational), StallCount/FlushCount out (saturating)
module id_ex_register
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W = mips_pkg::DATA_W,
  parameter int unsigned REG_AW = mips_pkg::REG_AW,
  parameter int unsigned CTRL_W = mips_pkg::CTRL_W,
  parameter int unsigned CNT_W  = mips_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  id_ex_register_if.slave  bus
);

  logic [DATA_W-1:0] ex_pcplus4_q;
  logic [DATA_W-1:0] ex_data1_q;
  logic [DATA_W-1:0] ex_data2_q;
  logic [DATA_W-1:0] ex_dataextra_q;
  logic [DATA_W-1:0] ex_imm_q;
  logic [REG_AW-1:0] ex_rs_q;
  logic [REG_AW-1:0] ex_rt_q;
  logic [REG_AW-1:0] ex_rd_q;
  logic [CTRL_W-1:0] ex_ctrl_q;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic [CNT_W-1:0]  flush_cnt_q;

  logic hazard_c;
  logic stall_c;
  logic bubble_c;

  // Load-use detection against the instruction currently held in EX
  hazard_detect #(
    .REG_AW (REG_AW)
  ) u_hazard_detect (
    .ex_memread (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt      (ex_rt_q),
    .id_rs      (bus.id_Rs),
    .id_rt      (bus.id_Rt),
    .flush      (bus.Flush),
    .hazard_c   (hazard_c),
    .stall_c    (stall_c)
  );

  // Either reason squashes the whole EX payload to zero
  assign bubble_c = bus.Flush || hazard_c;

  // Pipeline payload: bubble is all-zero, never hold-previous
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_pcplus4_q   <= '0;
      ex_data1_q     <= '0;
      ex_data2_q     <= '0;
      ex_dataextra_q <= '0;
      ex_imm_q       <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_ctrl_q      <= '0;
    end else if (bubble_c) begin
      ex_pcplus4_q   <= '0;
      ex_data1_q     <= '0;
      ex_data2_q     <= '0;
      ex_dataextra_q <= '0;
      ex_imm_q       <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_ctrl_q      <= '0;
    end else begin
      ex_pcplus4_q   <= bus.id_PCplus4;
      ex_data1_q     <= bus.id_Readdata1;
      ex_data2_q     <= bus.id_Readdata2;
      ex_dataextra_q <= bus.id_ReaddataExtra;
      ex_imm_q       <= bus.id_Imm;
      ex_rs_q        <= bus.id_Rs;
      ex_rt_q        <= bus.id_Rt;
      ex_rd_q        <= bus.id_Rd;
      ex_ctrl_q      <= bus.id_Ctrl;
    end
  end

  // Flush bubbles; a flush takes precedence so it is never also a stall
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flush_cnt_q <= '0;
    end else if (bus.Flush && (flush_cnt_q != '1)) begin
      flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  // Load-use bubbles, counted only when not overridden by a flush
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (!bus.Flush && hazard_c && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.ex_PCplus4   = ex_pcplus4_q;
  assign bus.ex_Data1     = ex_data1_q;
  assign bus.ex_Data2     = ex_data2_q;
  assign bus.ex_DataExtra = ex_dataextra_q;
  assign bus.ex_Imm       = ex_imm_q;
  assign bus.ex_Rs        = ex_rs_q;
  assign bus.ex_Rt        = ex_rt_q;
  assign bus.ex_Rd        = ex_rd_q;
  assign bus.ex_Ctrl      = ex_ctrl_q;
  assign bus.Stall        = stall_c;
  assign bus.StallCount   = stall_cnt_q;
  assign bus.FlushCount   = flush_cnt_q;

endmodule : id_ex_register

// File: tb/tb_id_ex_register.sv
// Self-checking bench for id_ex_register: expected EX snapshots are pushed to
// a queue as each cycle's inputs are driven and popped after the capturing edge.
module tb_id_ex_register;
  import mips_pkg::*;

  localparam int unsigned VW = 5*32 + 3*5 + 9 + 2*16;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  id_ex_register_if bus ();

  id_ex_register dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [VW-1:0] exp_q[$];
  logic [VW-1:0] got;
  logic [VW-1:0] exp_v;
  logic          exp_stall;

  // Reference state of the EX stage
  logic [31:0] m_pc, m_d1, m_d2, m_dx, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [8:0]  m_ctrl;
  logic [15:0] m_sc, m_fc;

  function automatic logic [VW-1:0] dut_vec();
    return {bus.ex_PCplus4, bus.ex_Data1, bus.ex_Data2, bus.ex_DataExtra,
            bus.ex_Imm, bus.ex_Rs, bus.ex_Rt, bus.ex_Rd, bus.ex_Ctrl,
            bus.StallCount, bus.FlushCount};
  endfunction

  function automatic logic [VW-1:0] model_vec();
    return {m_pc, m_d1, m_d2, m_dx, m_imm, m_rs, m_rt, m_rd, m_ctrl, m_sc, m_fc};
  endfunction

  task automatic model_reset();
    {m_pc, m_d1, m_d2, m_dx, m_imm} = '0;
    {m_rs, m_rt, m_rd, m_ctrl} = '0;
    m_sc = '0;
    m_fc = '0;
    exp_q.delete();
  endtask

  task automatic model_bubble();
    {m_pc, m_d1, m_d2, m_dx, m_imm} = '0;
    {m_rs, m_rt, m_rd, m_ctrl} = '0;
  endtask

  // Drive one decode-stage instruction and predict the next EX snapshot
  task automatic apply(input logic [31:0] pc, input logic [31:0] d1,
                       input logic [31:0] d2, input logic [31:0] dx,
                       input logic [31:0] imm, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [8:0] ctrl, input logic flush);
    logic haz;
    bus.id_PCplus4       = pc;
    bus.id_Readdata1     = d1;
    bus.id_Readdata2     = d2;
    bus.id_ReaddataExtra = dx;
    bus.id_Imm           = imm;
    bus.id_Rs            = rs;
    bus.id_Rt            = rt;
    bus.id_Rd            = rd;
    bus.id_Ctrl          = ctrl;
    bus.Flush            = flush;
    haz = m_ctrl[6] && (m_rt != 5'd0) && ((m_rt == rs) || (m_rt == rt));
    exp_stall = haz && !flush;
    if (flush) begin
      model_bubble();
      if (m_fc != 16'hFFFF) m_fc = m_fc + 16'd1;
    end else if (haz) begin
      model_bubble();
      if (m_sc != 16'hFFFF) m_sc = m_sc + 16'd1;
    end else begin
      m_pc = pc; m_d1 = d1; m_d2 = d2; m_dx = dx; m_imm = imm;
      m_rs = rs; m_rt = rt; m_rd = rd; m_ctrl = ctrl;
    end
    exp_q.push_back(model_vec());
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    apply(32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 9'h0, 1'b0);
    exp_q.delete();
    #2;
    checks++;
    if (dut_vec() !== VW'(0)) begin
      failures++;
      $display("FAIL reset_values got=%h exp=0", dut_vec());
    end
    tick();
    checks++;
    if (dut_vec() !== VW'(0)) begin
      failures++;
      $display("FAIL reset_held got=%h exp=0", dut_vec());
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_passthrough();
    apply(32'h0000_0104, 32'h1234_5678, 32'h0BAD_F00D, 32'h5555_AAAA,
          32'hFFFF_FFF0, 5'd3, 5'd4, 5'd7, 9'h1A3, 1'b0);
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      failures++;
      $display("FAIL pass_stall got=%b exp=0", bus.Stall);
    end
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL pass_capture got=%h exp=%h", got, exp_v);
    end
    checks++;
    if (bus.ex_Data1 !== 32'h1234_5678 || bus.ex_Rs !== 5'd3 || bus.ex_Ctrl !== 9'h1A3) begin
      failures++;
      $display("FAIL pass_fields got=%h/%0d/%h exp=12345678/3/1a3",
               bus.ex_Data1, bus.ex_Rs, bus.ex_Ctrl);
    end
  endtask

  task automatic test_load_use();
    apply(32'h108, 32'h11, 32'h22, 32'h33, 32'h4, 5'd1, 5'd5, 5'd0, 9'h0C8, 1'b0);
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL lu_load got=%h exp=%h", got, exp_v);
    end
    apply(32'h10C, 32'h55, 32'h66, 32'h77, 32'h8, 5'd5, 5'd2, 5'd9, 9'h183, 1'b0);
    #1;
    checks++;
    if (bus.Stall !== 1'b1 || exp_stall !== 1'b1) begin
      failures++;
      $display("FAIL lu_stall got=%b exp=1", bus.Stall);
    end
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.ex_Ctrl !== 9'h0 || bus.StallCount !== 16'd1) begin
      failures++;
      $display("FAIL lu_bubble got=%h exp=%h", got, exp_v);
    end
    apply(32'h10C, 32'h55, 32'h66, 32'h77, 32'h8, 5'd5, 5'd2, 5'd9, 9'h183, 1'b0);
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      failures++;
      $display("FAIL lu_stall_clear got=%b exp=0", bus.Stall);
    end
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL lu_held_capture got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_load_zero();
    apply(32'h110, 32'hA1, 32'hA2, 32'hA3, 32'h0, 5'd4, 5'd0, 5'd0, 9'h0C8, 1'b0);
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL lz_load got=%h exp=%h", got, exp_v);
    end
    apply(32'h114, 32'hB1, 32'hB2, 32'hB3, 32'h1, 5'd0, 5'd0, 5'd8, 9'h182, 1'b0);
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      failures++;
      $display("FAIL lz_stall got=%b exp=0", bus.Stall);
    end
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.StallCount !== 16'd1) begin
      failures++;
      $display("FAIL lz_capture got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    // load A -> $5, load B uses $5 and writes $6, consumer uses $6
    apply(32'h118, 32'h1, 32'h2, 32'h3, 32'h10, 5'd2, 5'd5, 5'd0, 9'h0C8, 1'b0);
    for (int k = 0; k < 2; k++) begin
      tick();
      got = dut_vec(); exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v) begin
        failures++;
        $display("FAIL b2b_load%0d got=%h exp=%h", k, got, exp_v);
      end
      if (k == 0)
        apply(32'h11C, 32'h4, 32'h5, 32'h6, 32'h20, 5'd5, 5'd6, 5'd0, 9'h0C8, 1'b0);
      else
        apply(32'h120, 32'h7, 32'h8, 32'h9, 32'h30, 5'd6, 5'd1, 5'd3, 9'h1A2, 1'b0);
      #1;
      checks++;
      if (bus.Stall !== 1'b1) begin
        failures++;
        $display("FAIL b2b_stall%0d got=%b exp=1", k, bus.Stall);
      end
      tick();
      got = dut_vec(); exp_v = exp_q.pop_front();
      checks++;
      if (got !== exp_v || bus.ex_Ctrl !== 9'h0) begin
        failures++;
        $display("FAIL b2b_bubble%0d got=%h exp=%h", k, got, exp_v);
      end
      if (k == 0)
        apply(32'h11C, 32'h4, 32'h5, 32'h6, 32'h20, 5'd5, 5'd6, 5'd0, 9'h0C8, 1'b0);
      else
        apply(32'h120, 32'h7, 32'h8, 32'h9, 32'h30, 5'd6, 5'd1, 5'd3, 9'h1A2, 1'b0);
    end
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.StallCount !== 16'd3) begin
      failures++;
      $display("FAIL b2b_consumer got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_reset_mid();
    apply(32'h124, 32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd7, 5'd8, 5'd9, 9'h1A3, 1'b0);
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.ex_Data1 !== 32'hDEAD_BEEF || bus.StallCount !== 16'd3) begin
      failures++;
      $display("FAIL rm_loaded got=%h exp=%h", got, exp_v);
    end
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== VW'(0)) begin
      failures++;
      $display("FAIL rm_async_clear got=%h exp=0", dut_vec());
    end
    tick();
    checks++;
    if (dut_vec() !== VW'(0)) begin
      failures++;
      $display("FAIL rm_held got=%h exp=0", dut_vec());
    end
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    apply(32'h128, 32'hCAFE_F00D, 32'h9, 32'h8, 32'h7, 5'd10, 5'd11, 5'd12, 9'h123, 1'b0);
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.ex_Data1 !== 32'hCAFE_F00D) begin
      failures++;
      $display("FAIL rm_first_capture got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_flush_hazard();
    apply(32'h12C, 32'h1, 32'h2, 32'h3, 32'h4, 5'd1, 5'd5, 5'd0, 9'h0C8, 1'b0);
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v) begin
      failures++;
      $display("FAIL fh_load got=%h exp=%h", got, exp_v);
    end
    apply(32'h130, 32'h5, 32'h6, 32'h7, 32'h8, 5'd5, 5'd2, 5'd4, 9'h183, 1'b1);
    #1;
    checks++;
    if (bus.Stall !== 1'b0) begin
      failures++;
      $display("FAIL fh_stall got=%b exp=0", bus.Stall);
    end
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.FlushCount !== 16'd1 || bus.StallCount !== 16'd0) begin
      failures++;
      $display("FAIL fh_bubble got=%h exp=%h", got, exp_v);
    end
  endtask

  task automatic test_saturation();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    model_reset();
    for (int i = 0; i < 32'h1_0001; i++) begin
      apply(32'h200, 32'h1, 32'h2, 32'h3, 32'h4, 5'd1, 5'd2, 5'd3, 9'h1A3, 1'b1);
      tick();
      got = dut_vec(); exp_v = exp_q.pop_front();
      if (i == 32'hFFFD) begin
        checks++;
        if (bus.FlushCount !== 16'hFFFE) begin
          failures++;
          $display("FAIL sat_below got=%h exp=fffe", bus.FlushCount);
        end
      end
      if (i == 32'hFFFE) begin
        checks++;
        if (bus.FlushCount !== 16'hFFFF) begin
          failures++;
          $display("FAIL sat_reach got=%h exp=ffff", bus.FlushCount);
        end
      end
    end
    checks++;
    if (got !== exp_v || bus.FlushCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_hold got=%h exp=%h", got, exp_v);
    end
    apply(32'h204, 32'h9, 32'h8, 32'h7, 32'h6, 5'd4, 5'd5, 5'd6, 9'h1A3, 1'b0);
    tick();
    got = dut_vec(); exp_v = exp_q.pop_front();
    checks++;
    if (got !== exp_v || bus.FlushCount !== 16'hFFFF) begin
      failures++;
      $display("FAIL sat_after got=%h exp=%h", got, exp_v);
    end
  endtask

  initial begin
    model_reset();
    exp_stall = 1'b0;
    got = '0;
    exp_v = '0;
    test_reset();
    test_passthrough();
    test_load_use();
    test_load_zero();
    test_back_to_back();
    test_reset_mid();
    test_flush_hazard();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule : tb_id_ex_register
